// File: rtl/mac_byte_seq.sv
// mac_byte_seq: byte-serial multiply-accumulate sequencer.
// Takes n_terms (X, W) byte pairs over a valid/ready input and sums the
// unsigned products X*W. The final sum is held on a valid/ready output.
// Optional build macro: MAC_SAT_EN. When it is defined, the accumulator
// saturates on overflow. When it is undefined, the accumulator wraps modulo
// 2^ACC_W. ACC_W must be >= 2*DATA_W.
module mac_byte_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_X = 3'd1,
    LD_W = 3'd2,
    MAC  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] x_reg;
  logic [DATA_W-1:0] w_reg;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;

  logic              in_hs_c;
  logic              out_hs_c;
  logic              last_term_c;
  logic [PROD_W-1:0] prod_c;
  logic [SUM_W-1:0]  sum_c;
  logic              sum_ovf_c;
  logic [ACC_W-1:0]  acc_mac_c;

  // A byte handshake or a result handshake completes on this cycle.
  assign in_hs_c     = in_valid && in_ready;
  assign out_hs_c    = out_valid && out_ready;
  assign last_term_c = (cnt == CNT_W'(1));

  // The product is zero-extended, and the sum keeps one carry bit above
  // the accumulator.
  always_comb begin
    prod_c    = PROD_W'(x_reg) * PROD_W'(w_reg);
    sum_c     = SUM_W'(acc) + SUM_W'(prod_c);
    sum_ovf_c = sum_c[ACC_W];
`ifdef MAC_SAT_EN
    acc_mac_c = sum_ovf_c ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
    acc_mac_c = sum_c[ACC_W-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. start is honoured only in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (n_terms != '0) ? LD_X : DONE;
        end
      end
      LD_X: begin
        if (in_hs_c) begin
          state_nxt = LD_W;
        end
      end
      LD_W: begin
        if (in_hs_c) begin
          state_nxt = MAC;
        end
      end
      MAC: begin
        state_nxt = last_term_c ? DONE : LD_X;
      end
      DONE: begin
        if (out_hs_c) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake and status outputs are registered from the next state.
  // They therefore always match the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == LD_X) || (state_nxt == LD_W);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

  // Datapath: operand capture, accumulation, term count, result and overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg    <= '0;
      w_reg    <= '0;
      cnt      <= '0;
      acc      <= '0;
      out_data <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= n_terms;
            if (n_terms == '0) begin
              out_data <= '0;
            end
          end
        end
        LD_X: begin
          if (in_hs_c) begin
            x_reg <= in_data;
          end
        end
        LD_W: begin
          if (in_hs_c) begin
            w_reg <= in_data;
          end
        end
        MAC: begin
          acc <= acc_mac_c;
          cnt <= cnt - CNT_W'(1);
          if (sum_ovf_c) begin
            ovf <= 1'b1;
          end
          if (last_term_c) begin
            out_data <= acc_mac_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_byte_seq.sv
// Directed bench for mac_byte_seq. The default-width instance and a 17-bit
// accumulator instance share all inputs. The narrow instance is used for
// the overflow case.
module tb_mac_byte_seq;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  n_terms;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic              in_ready;
  logic              out_valid;
  logic [19:0]       out_data;
  logic              busy;
  logic              ovf;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [16:0]       s_out_data;
  logic              s_busy;
  logic              s_ovf;

  int pass_cnt;
  int total_cnt;
  int fail_cnt;

  mac_byte_seq #(.DATA_W(8), .ACC_W(20), .CNT_W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_terms   (n_terms),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  mac_byte_seq #(.DATA_W(8), .ACC_W(17), .CNT_W(4)) u_dut17 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_terms   (n_terms),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (s_in_ready),
    .out_valid (s_out_valid),
    .out_data  (s_out_data),
    .out_ready (out_ready),
    .busy      (s_busy),
    .ovf       (s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start   = 1'b1;
    n_terms = n;
    tick();
    start   = 1'b0;
  endtask

  // Present one byte and return just after the edge that accepts it.
  task automatic send_byte(input logic [DATA_W-1:0] d);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!in_ready) chk("send_byte_timeout", 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [DATA_W-1:0] bp_bytes [4];
    int idx;
    int cyc;
    logic hs;

    pass_cnt  = 0;
    total_cnt = 0;
    fail_cnt  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    n_terms   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Check the values held after reset.
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    // Basic sum: 2*3 + 4*5 + 10*10 = 126 with in_valid held high.
    do_start(4'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    send_byte(8'd2);
    send_byte(8'd3);
    send_byte(8'd4);
    send_byte(8'd5);
    send_byte(8'd10);
    send_byte(8'd10);
    chk("t1_valid_1edge", 32'(out_valid), 32'd0);
    chk("t1_in_ready_mac", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t1_valid_2edge", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'd126);
    chk("t1_ovf", 32'(ovf), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_data_kept", 32'(out_data), 32'd126);

    // Zero terms: the result of 0 appears one edge after start.
    do_start(4'd0);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'd0);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_valid_drop", 32'(out_valid), 32'd0);
    chk("t2_in_ready_idle", 32'(in_ready), 32'd0);

    // Backpressure: 3*7 + 9*2 = 39. in_valid toggles, and a garbage byte
    // is presented whenever in_valid is low.
    bp_bytes[0] = 8'd3;
    bp_bytes[1] = 8'd7;
    bp_bytes[2] = 8'd9;
    bp_bytes[3] = 8'd2;
    do_start(4'd2);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 60) begin
      in_valid = cyc[0];
      in_data  = in_valid ? bp_bytes[idx] : 8'hEE;
      hs = in_valid && in_ready;
      tick();
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("t3_all_bytes", 32'(idx), 32'd4);
    wait_valid("t3_wait_valid");
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_data", 32'(out_data), 32'd39);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_valid_drop", 32'(out_valid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);

    // Overflow: 3*255*255 = 195075. A 17-bit accumulator wraps to 64003 or
    // saturates at 131071.
    do_start(4'd3);
    for (int i = 0; i < 6; i++) send_byte(8'd255);
    in_valid = 1'b0;
    wait_valid("t4_wait_valid");
    chk("t4_wide_data", 32'(out_data), 32'd195075);
    chk("t4_wide_ovf", 32'(ovf), 32'd0);
    chk("t4_n17_valid", 32'(s_out_valid), 32'd1);
`ifdef MAC_SAT_EN
    chk("t4_n17_data", 32'(s_out_data), 32'd131071);
`else
    chk("t4_n17_data", 32'(s_out_data), 32'd64003);
`endif
    chk("t4_n17_ovf", 32'(s_ovf), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_n17_ovf_idle", 32'(s_ovf), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);

    // Reset mid-operation, just after X of term 2 has been accepted.
    do_start(4'd3);
    send_byte(8'd1);
    send_byte(8'd2);
    send_byte(8'd3);
    in_valid = 1'b0;
    chk("t5_in_ldw", 32'(in_ready), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_out_data", 32'(out_data), 32'd0);
    chk("t5_n17_ovf", 32'(s_ovf), 32'd0);
    do_start(4'd1);
    send_byte(8'd7);
    send_byte(8'd6);
    in_valid = 1'b0;
    wait_valid("t5_wait_valid");
    chk("t5_data", 32'(out_data), 32'd42);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // start pulses during LD_W and DONE are ignored: 4*5 + 6*7 = 62.
    do_start(4'd2);
    send_byte(8'd4);
    start   = 1'b1;
    n_terms = 4'd1;
    send_byte(8'd5);
    start   = 1'b0;
    send_byte(8'd6);
    send_byte(8'd7);
    in_valid = 1'b0;
    wait_valid("t6_wait_valid");
    chk("t6_data", 32'(out_data), 32'd62);
    start   = 1'b1;
    n_terms = 4'd0;
    tick();
    start   = 1'b0;
    chk("t6_done_valid", 32'(out_valid), 32'd1);
    chk("t6_done_data", 32'(out_data), 32'd62);
    chk("t6_done_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_valid_drop", 32'(out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
